// File: rtl/adder_sweep_checker.sv
// Exhaustive self-test driver/checker for an N-bit adder: walks every in0/in1 pair,
// compares {dut_cout,dut_out} with the exact sum and reports error count and first failure.
module adder_sweep_checker #(
  parameter int WIDTH       = 4,
  parameter int DUT_LATENCY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   in0,
  output logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   dut_out,
  input  logic               dut_cout,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               first_err_vld,
  output logic [WIDTH-1:0]   first_err_in0,
  output logic [WIDTH-1:0]   first_err_in1,
  output logic [1:0]         state_dbg
);

  localparam int VW = 2 * WIDTH;
  localparam int CW = (DUT_LATENCY > 1) ? $clog2(DUT_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [VW-1:0]    vec;
  logic [CW-1:0]    drain_cnt;
  logic             last_vec;
  logic             drain_end;
  logic             start_ok;
  logic             chk_vld;
  logic [VW-1:0]    chk_vec;
  logic [WIDTH:0]   exp_sum;
  logic             mismatch;

  assign last_vec  = (vec == {VW{1'b1}});
  assign drain_end = (drain_cnt == CW'(DUT_LATENCY - 1));
  assign start_ok  = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_vec) state_nxt = (DUT_LATENCY == 0) ? DONE : DRAIN;
      DRAIN:   if (drain_end) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // vec is the operand register itself; it parks on the last pair after the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok)
        vec <= '0;
      else if ((state == RUN) && !last_vec)
        vec <= vec + 1'b1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  // Operand copies follow the adder's latency so each result meets its own vector.
  generate
    if (DUT_LATENCY == 0) begin : g_nodly
      assign chk_vld = (state == RUN);
      assign chk_vec = vec;
    end else begin : g_dly
      logic [DUT_LATENCY-1:0] vld_sr;
      logic [VW-1:0]          vec_sr [DUT_LATENCY];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_sr <= '0;
          for (int i = 0; i < DUT_LATENCY; i++) vec_sr[i] <= '0;
        end else begin
          vld_sr[0] <= (state == RUN);
          vec_sr[0] <= vec;
          for (int i = 1; i < DUT_LATENCY; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            vec_sr[i] <= vec_sr[i-1];
          end
        end
      end

      assign chk_vld = vld_sr[DUT_LATENCY-1];
      assign chk_vec = vec_sr[DUT_LATENCY-1];
    end
  endgenerate

  assign exp_sum  = {1'b0, chk_vec[VW-1:WIDTH]} + {1'b0, chk_vec[WIDTH-1:0]};
  // Case inequality so X/Z returned by the adder is treated as a failure.
  assign mismatch = ({dut_cout, dut_out} !== exp_sum);

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      err_count     <= '0;
      first_err_vld <= 1'b0;
      first_err_in0 <= '0;
      first_err_in1 <= '0;
    end else if (chk_vld && mismatch) begin
      err_count <= err_count + 1'b1;
      if (!first_err_vld) begin
        first_err_vld <= 1'b1;
        first_err_in0 <= chk_vec[VW-1:WIDTH];
        first_err_in1 <= chk_vec[WIDTH-1:0];
      end
    end
  end

  assign in0       = vec[VW-1:WIDTH];
  assign in1       = vec[WIDTH-1:0];
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign pass      = done && (err_count == '0);
  assign state_dbg = state;

endmodule

// File: tb/tb_adder_sweep_checker.sv
// Bench for adder_sweep_checker: a combinational/registered/faulty adder model on a LAT=0
// instance and a registered adder on a LAT=1 instance, checked by a queued scoreboard.
module tb_adder_sweep_checker;

  localparam int N = 256;

  typedef struct packed {
    logic [8:0] err;
    logic       fv;
    logic [3:0] f0;
    logic [3:0] f1;
    logic       pass;
    logic [9:0] lat;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [1:0]      start_w;
  logic [1:0][3:0] in0_w, in1_w, dout_w, f0_w, f1_w;
  logic [1:0]      cout_w, busy_w, done_w, pass_w, fv_w;
  logic [1:0][8:0] err_w;
  logic [1:0][1:0] st_w;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          c_s [2];
  logic [1:0]  act = 2'b00;
  logic [1:0]  done_q = 2'b00;
  int          last_pair [2];
  exp_t        exp_q0 [$];
  exp_t        exp_q1 [$];

  int          mode_a;
  logic        reg_a;
  logic [3:0]  fa, fb;
  int          fbit;
  logic [4:0]  a_reg, b_reg;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs and adder models ----------------
  adder_sweep_checker #(.WIDTH(4), .DUT_LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .start(start_w[0]), .in0(in0_w[0]), .in1(in1_w[0]),
    .dut_out(dout_w[0]), .dut_cout(cout_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_count(err_w[0]), .first_err_vld(fv_w[0]),
    .first_err_in0(f0_w[0]), .first_err_in1(f1_w[0]), .state_dbg(st_w[0])
  );

  adder_sweep_checker #(.WIDTH(4), .DUT_LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start_w[1]), .in0(in0_w[1]), .in1(in1_w[1]),
    .dut_out(dout_w[1]), .dut_cout(cout_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_count(err_w[1]), .first_err_vld(fv_w[1]),
    .first_err_in0(f0_w[1]), .first_err_in1(f1_w[1]), .state_dbg(st_w[1])
  );

  // mode 0 good, 1 cout stuck-at-0, 3 bit flip when a==fa, 4 X result on (fa,fb)
  function automatic logic [4:0] adder_f(input int mode, input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] fa_i, input logic [3:0] fb_i,
                                         input int fbit_i);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (mode)
      1: s[4] = 1'b0;
      3: if (a == fa_i) s[fbit_i] = ~s[fbit_i];
      4: if (a == fa_i && b == fb_i) s = 'x;
      default: ;
    endcase
    return s;
  endfunction

  always @(posedge clk) a_reg <= adder_f(mode_a, in0_w[0], in1_w[0], fa, fb, fbit);
  always @(posedge clk) b_reg <= {1'b0, in0_w[1]} + {1'b0, in1_w[1]};
  assign {cout_w[0], dout_w[0]} = reg_a ? a_reg : adder_f(mode_a, in0_w[0], in1_w[0], fa, fb, fbit);
  assign {cout_w[1], dout_w[1]} = b_reg;

  // ---------------- reference model ----------------
  // Result observed for vector k is the adder's function of whatever pair was on the
  // bus (checker latency L - adder delay D) cycles away from k, clamped to the sweep.
  function automatic exp_t model(input int L, input int D, input int mode, input int prev,
                                 input logic [3:0] fa_i, input logic [3:0] fb_i, input int fbit_i);
    exp_t       e;
    int         j;
    logic [4:0] obs, want;
    e = '0;
    for (int k = 0; k < N; k++) begin
      j = k + L - D;
      if (j < 0) j = prev;
      else if (j >= N) j = N - 1;
      obs  = adder_f(mode, 4'(j / 16), 4'(j % 16), fa_i, fb_i, fbit_i);
      want = 5'(k / 16 + k % 16);
      if (obs !== want) begin
        if (!e.fv) begin
          e.fv = 1'b1;
          e.f0 = 4'(k / 16);
          e.f1 = 4'(k % 16);
        end
        e.err = e.err + 9'd1;
      end
    end
    e.pass = (e.err == 9'd0);
    e.lat  = 10'(N + 1 + L);
    return e;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s inst%0d @cyc %0d: got %0h required %0h", nm, inst, cyc, got, want);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   t;
      exp_t e;
      if (act[i]) begin
        t = cyc - c_s[i];
        if (t >= 1) begin
          chk("busy", i, 32'(busy_w[i]), 32'(t <= N + i));
          if (t <= N + i) chk("done_early", i, 32'(done_w[i]), 32'(0));
          chk("operands", i, 32'({in0_w[i], in1_w[i]}), 32'((t <= N) ? t - 1 : N - 1));
          if (done_w[i] === 1'b1 && done_q[i] !== 1'b1) begin
            if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_done inst%0d @cyc %0d: got done=1 required no result", i, cyc);
            end else begin
              e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
              chk("done_latency", i, 32'(t), 32'(e.lat));
              chk("err_count", i, 32'(err_w[i]), 32'(e.err));
              chk("first_err_vld", i, 32'(fv_w[i]), 32'(e.fv));
              chk("first_err_in0", i, 32'(f0_w[i]), 32'(e.f0));
              chk("first_err_in1", i, 32'(f1_w[i]), 32'(e.f1));
              chk("pass", i, 32'(pass_w[i]), 32'(e.pass));
            end
          end
        end
      end
      done_q[i] = done_w[i];
    end
  end

  // ---------------- driver ----------------
  task automatic sweep(input int i, input int hold);
    exp_t e;
    int   w;
    if (i == 0) begin
      e = model(0, reg_a ? 1 : 0, mode_a, last_pair[0], fa, fb, fbit);
      exp_q0.push_back(e);
    end else begin
      e = model(1, 1, 0, last_pair[1], fa, fb, fbit);
      exp_q1.push_back(e);
    end
    @(negedge clk);
    start_w[i] = 1'b1;
    c_s[i]     = cyc;
    act[i]     = 1'b1;
    repeat (hold) @(negedge clk);
    start_w[i] = 1'b0;
    w = 0;
    while (!(done_w[i] === 1'b1 && cyc > c_s[i]) && w < N + 40) begin
      @(negedge clk);
      w++;
    end
    if (w >= N + 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL sweep_timeout inst%0d: got done=%b required 1", i, done_w[i]);
      if (i == 0 && exp_q0.size() > 0) void'(exp_q0.pop_front());
      if (i == 1 && exp_q1.size() > 0) void'(exp_q1.pop_front());
    end
    @(negedge clk);
    act[i]       = 1'b0;
    last_pair[i] = N - 1;
  endtask

  task automatic check_idle_zero(input int i, input string tag);
    chk({tag, "_busy"}, i, 32'(busy_w[i]), 32'(0));
    chk({tag, "_done"}, i, 32'(done_w[i]), 32'(0));
    chk({tag, "_pass"}, i, 32'(pass_w[i]), 32'(0));
    chk({tag, "_err"}, i, 32'(err_w[i]), 32'(0));
    chk({tag, "_fvld"}, i, 32'(fv_w[i]), 32'(0));
    chk({tag, "_fin"}, i, 32'({f0_w[i], f1_w[i]}), 32'(0));
    chk({tag, "_ops"}, i, 32'({in0_w[i], in1_w[i]}), 32'(0));
    chk({tag, "_state"}, i, 32'(st_w[i]), 32'(0));
  endtask

  int modes [4] = '{0, 1, 3, 4};

  initial begin
    rst     = 1'b1;
    start_w = 2'b00;
    mode_a  = 0;
    reg_a   = 1'b0;
    fa      = '0;
    fb      = '0;
    fbit    = 0;
    last_pair[0] = 0;
    last_pair[1] = 0;

    // reset held two cycles
    repeat (2) @(negedge clk);
    check_idle_zero(0, "reset");
    check_idle_zero(1, "reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // good combinational adder, then cout stuck-at-0
    sweep(0, 1);
    mode_a = 1;
    sweep(0, 1);

    // registered adder: matched latency, then mismatched latency
    sweep(1, 1);
    mode_a = 0;
    reg_a  = 1'b1;
    sweep(0, 1);

    // reset while vector 100 is on the bus (faulty adder so errors are pending)
    mode_a = 1;
    reg_a  = 1'b0;
    @(negedge clk);
    start_w[0] = 1'b1;
    c_s[0]     = cyc;
    act[0]     = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    while (cyc - c_s[0] < 101) @(negedge clk);
    chk("abort_vec", 0, 32'({in0_w[0], in1_w[0]}), 32'(100));
    chk("abort_err_before", 0, 32'(err_w[0]), 32'(15));
    act[0] = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    check_idle_zero(0, "abort");
    rst = 1'b0;
    last_pair[0] = 0;
    last_pair[1] = 0;
    mode_a = 0;
    sweep(0, 1);

    // start held through RUN, then restarts from DONE: faulty then fixed adder
    sweep(0, 200);
    mode_a = 1;
    sweep(0, 1);
    mode_a = 0;
    sweep(0, 1);

    // randomized fault patterns and idle gaps
    for (int r = 0; r < 5; r++) begin
      mode_a = modes[$urandom_range(0, 3)];
      reg_a  = 1'($urandom_range(0, 1));
      fa     = 4'($urandom_range(0, 15));
      fb     = 4'($urandom_range(0, 15));
      fbit   = $urandom_range(0, 4);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      sweep(0, $urandom_range(1, 3));
    end
    sweep(1, $urandom_range(1, 3));

    repeat (3) @(negedge clk);
    chk("queue0_empty", 0, 32'(exp_q0.size()), 32'(0));
    chk("queue1_empty", 1, 32'(exp_q1.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
